// File: rtl/dwt97_pkg.sv
// dwt97_pkg: shared subband encoding and saturation helper for the DWT 9/7 quantizer.
`default_nettype none

package dwt97_pkg;

  typedef enum logic [1:0] {
    LL = 2'd0,
    LH = 2'd1,
    HL = 2'd2,
    HH = 2'd3
  } subband_e;

  localparam int unsigned SAT_W = 64;

  // Clamp an unsigned magnitude to the largest positive value of a qwidth-bit signed index.
  function automatic logic [SAT_W-1:0] sat_signed(input logic [SAT_W-1:0] mag,
                                                  input int unsigned qwidth);
    logic [SAT_W-1:0] limit;
    limit = (SAT_W'(1) << (qwidth - 1)) - SAT_W'(1);
    return (mag > limit) ? limit : mag;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dwt97_quant_lane.sv
// dwt97_quant_lane: one dead-zone quantizer lane (abs, multiply, shift, saturate, sign restore).
`default_nettype none

module dwt97_quant_lane
  import dwt97_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int StepWidth = 16,
  parameter int Point     = 10,
  parameter int StepPoint = 15,
  parameter int QWidth    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_s1,
  input  logic                 load_s2,
  input  logic [DataWidth-1:0] x,
  input  logic [StepWidth-1:0] step,
  output logic [QWidth-1:0]    q
);

  localparam int ProdWidth = DataWidth + StepWidth;
  localparam int Shift     = Point + StepPoint;

  logic [DataWidth-1:0] mag;
  logic [ProdWidth-1:0] prod_d;
  logic [ProdWidth-1:0] prod_q;
  logic                 neg_q;
  logic [ProdWidth-1:0] m;
  logic [SAT_W-1:0]     m_sat;
  logic [QWidth-1:0]    m_q;
  logic [QWidth-1:0]    q_d;

  // Unsigned view keeps |-2^(DataWidth-1)| exact.
  assign mag    = x[DataWidth-1] ? (~x + DataWidth'(1)) : x;
  assign prod_d = ProdWidth'(mag) * ProdWidth'(step);

  assign m     = prod_q >> Shift;
  assign m_sat = sat_signed(SAT_W'(m), QWidth);
  assign m_q   = QWidth'(m_sat);
  assign q_d   = neg_q ? (~m_q + QWidth'(1)) : m_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q <= '0;
      neg_q  <= 1'b0;
      q      <= '0;
    end else begin
      if (load_s1) begin
        prod_q <= prod_d;
        neg_q  <= x[DataWidth-1];
      end
      if (load_s2) begin
        q <= q_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dwt97_deadzone_quantizer.sv
// dwt97_deadzone_quantizer: two-lane per-subband dead-zone quantizer with valid/ready framing.
`default_nettype none

module dwt97_deadzone_quantizer
  import dwt97_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int Point     = 10,
  parameter int StepWidth = 16,
  parameter int StepPoint = 15,
  parameter int QWidth    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [4*StepWidth-1:0] inv_step_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*QWidth-1:0]    m_data_o
);

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_sof;
  logic                 s1_eol;
  logic                 parity;
  logic [StepWidth-1:0] step_q [4];

  logic                 s2_adv;
  logic                 accept;
  logic                 load_s2;
  logic                 col;
  subband_e             sb_low;
  subband_e             sb_high;
  logic [StepWidth-1:0] step_low;
  logic [StepWidth-1:0] step_high;

  assign s2_adv    = !s2_valid || m_ready_i;
  assign s_ready_o = !s1_valid || s2_adv;
  assign accept    = s_valid_i && s_ready_o;
  assign load_s2   = s2_adv && s1_valid;
  assign m_valid_o = s2_valid;

  // A sof beat is column 0 and sees the steps being latched on the same edge.
  always_comb begin
    col       = s_sof_i ? 1'b0 : parity;
    sb_low    = col ? HL : LL;
    sb_high   = col ? HH : LH;
    step_low  = s_sof_i ? inv_step_i[int'(sb_low)*StepWidth +: StepWidth]  : step_q[sb_low];
    step_high = s_sof_i ? inv_step_i[int'(sb_high)*StepWidth +: StepWidth] : step_q[sb_high];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      m_sof_o  <= 1'b0;
      m_eol_o  <= 1'b0;
      parity   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        step_q[i] <= '0;
      end
    end else begin
      if (s_ready_o) begin
        s1_valid <= s_valid_i;
      end
      if (accept) begin
        s1_sof <= s_sof_i;
        s1_eol <= s_eol_i;
        parity <= s_eol_i ? 1'b0 : ~col;
        if (s_sof_i) begin
          for (int i = 0; i < 4; i++) begin
            step_q[i] <= inv_step_i[i*StepWidth +: StepWidth];
          end
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        m_sof_o  <= s1_valid && s1_sof;
        m_eol_o  <= s1_valid && s1_eol;
      end
    end
  end

  dwt97_quant_lane #(
    .DataWidth (DataWidth),
    .StepWidth (StepWidth),
    .Point     (Point),
    .StepPoint (StepPoint),
    .QWidth    (QWidth)
  ) u_lane_low (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_s1 (accept),
    .load_s2 (load_s2),
    .x       (s_data_i[DataWidth-1:0]),
    .step    (step_low),
    .q       (m_data_o[QWidth-1:0])
  );

  dwt97_quant_lane #(
    .DataWidth (DataWidth),
    .StepWidth (StepWidth),
    .Point     (Point),
    .StepPoint (StepPoint),
    .QWidth    (QWidth)
  ) u_lane_high (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_s1 (accept),
    .load_s2 (load_s2),
    .x       (s_data_i[2*DataWidth-1:DataWidth]),
    .step    (step_high),
    .q       (m_data_o[2*QWidth-1:QWidth])
  );

endmodule

`default_nettype wire

// File: tb/tb_dwt97_deadzone_quantizer.sv
// tb_dwt97_deadzone_quantizer: randomized scoreboard bench, 16-bit and 6-bit output variants.
`default_nettype none

module tb_dwt97_deadzone_quantizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] inv_step;
  logic        s_valid, s_sof, s_eol;
  logic [31:0] s_data;
  logic        m_ready;

  logic        s_ready, m_valid, m_sof, m_eol;
  logic [31:0] m_data;
  logic        s_ready6, m_valid6, m_sof6, m_eol6;
  logic [11:0] m_data6;

  always #5 clk = ~clk;

  dwt97_deadzone_quantizer #(.QWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .inv_step_i(inv_step), .s_ready_o(s_ready),
    .s_valid_i(s_valid), .s_sof_i(s_sof), .s_eol_i(s_eol), .s_data_i(s_data),
    .m_ready_i(m_ready), .m_valid_o(m_valid), .m_sof_o(m_sof), .m_eol_o(m_eol),
    .m_data_o(m_data)
  );

  dwt97_deadzone_quantizer #(.QWidth(6)) dut6 (
    .clk_i(clk), .rst_i(rst), .inv_step_i(inv_step), .s_ready_o(s_ready6),
    .s_valid_i(s_valid), .s_sof_i(s_sof), .s_eol_i(s_eol), .s_data_i(s_data),
    .m_ready_i(m_ready), .m_valid_o(m_valid6), .m_sof_o(m_sof6), .m_eol_o(m_eol6),
    .m_data_o(m_data6)
  );

  typedef struct {
    int ql;
    int qh;
    int ql6;
    int qh6;
    int sof;
    int eol;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          passes = 0;
  int          mcol;
  int          mstep[4];
  bit          acc_flag;
  bit          hold_pending;
  logic [31:0] held;
  int          rdy_mode;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // q = sign(x) * floor(|x| * step / 2^25), clamped to the qw-bit signed maximum.
  function automatic int quant(input int x, input int step, input int qw);
    longint mag, m, lim;
    mag = (x < 0) ? -longint'(x) : longint'(x);
    m   = (mag * longint'(step)) / (longint'(1) << 25);
    lim = (longint'(1) << (qw - 1)) - 1;
    if (m > lim) m = lim;
    return (x < 0) ? -int'(m) : int'(m);
  endfunction

  always @(negedge clk) begin
    int   xl, xh, sl, sh;
    exp_t e;
    if (rst) begin
      expq.delete();
      mcol         = 0;
      mstep        = '{0, 0, 0, 0};
      acc_flag     = 1'b0;
      hold_pending = 1'b0;
    end else begin
      acc_flag = s_valid && s_ready;
      if (acc_flag) begin
        if (s_sof) begin
          for (int i = 0; i < 4; i++) mstep[i] = int'(inv_step[16*i +: 16]);
          mcol = 0;
        end
        xl = $signed(s_data[15:0]);
        xh = $signed(s_data[31:16]);
        sl = mcol ? mstep[2] : mstep[0];
        sh = mcol ? mstep[3] : mstep[1];
        e.ql  = quant(xl, sl, 16);
        e.qh  = quant(xh, sh, 16);
        e.ql6 = quant(xl, sl, 6);
        e.qh6 = quant(xh, sh, 6);
        e.sof = int'(s_sof);
        e.eol = int'(s_eol);
        expq.push_back(e);
        mcol = s_eol ? 0 : 1 - mcol;
      end
      if (hold_pending) begin
        check("hold_valid", int'(m_valid), 1);
        check("hold_data", int'(m_data), int'(held));
      end
      hold_pending = m_valid && !m_ready;
      held         = m_data;
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          check("spurious_out", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          check("q_low", $signed(m_data[15:0]), e.ql);
          check("q_high", $signed(m_data[31:16]), e.qh);
          check("q6_low", $signed(m_data6[5:0]), e.ql6);
          check("q6_high", $signed(m_data6[11:6]), e.qh6);
          check("sof", int'(m_sof), e.sof);
          check("eol", int'(m_eol), e.eol);
        end
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        2:       m_ready = 1'b0;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic signed [15:0] h, input logic signed [15:0] l,
                      input logic sof, input logic eol);
    int guard;
    s_valid = 1'b1;
    s_data  = {h, l};
    s_sof   = sof;
    s_eol   = eol;
    guard   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_flag) break;
      guard++;
      if (guard > 100) begin
        check("accept_timeout", guard, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] rand_x();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'd1023;
      3:       return 16'hFC01;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int guard;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0;
    inv_step = '0; rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(m_valid), 0);
    check("rst_sof", int'(m_sof), 0);
    check("rst_eol", int'(m_eol), 0);
    check("rst_data", int'(m_data), 0);
    check("rst_s_ready", int'(s_ready), 1);
    rst = 1'b0;
    idle(1);

    // Basic sof beat and its two-cycle latency.
    inv_step = {4{16'h4000}};
    send(-16'sd3072, 16'sd5120, 1'b1, 1'b0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t1_valid", int'(m_valid), 1);
    check("t1_q_high", $signed(m_data[31:16]), -1);
    check("t1_q_low", $signed(m_data[15:0]), 2);
    check("t1_sof", int'(m_sof), 1);
    idle(3);

    // Subband selection with parity cleared by eol on the second beat.
    inv_step = {16'h1000, 16'h2000, 16'h4000, 16'h8000};
    send(16'sd4096, 16'sd4096, 1'b1, 1'b0);
    send(16'sd4096, 16'sd4096, 1'b0, 1'b1);
    send(16'sd4096, 16'sd4096, 1'b0, 1'b0);
    send(16'sd4096, 16'sd4096, 1'b0, 1'b0);
    // Mid-frame step change must be ignored.
    inv_step = {4{16'hFFFF}};
    send(16'sd4096, -16'sd4096, 1'b0, 1'b0);
    send(-16'sd4096, 16'sd4096, 1'b0, 1'b1);
    idle(4);

    // Dead zone around zero.
    inv_step = {4{16'h8000}};
    send(16'sd1023, -16'sd1023, 1'b1, 1'b0);
    send(-16'sd1023, 16'sd1023, 1'b0, 1'b1);
    // Extreme magnitudes; the 6-bit variant saturates.
    inv_step = {4{16'hFFFF}};
    send(-16'sd32768, -16'sd32768, 1'b1, 1'b1);
    send(16'sd32767, -16'sd1, 1'b0, 1'b0);
    send(16'sd0, 16'sd32767, 1'b0, 1'b1);
    idle(4);

    // Back-pressure during a continuous burst.
    inv_step = {16'h3000, 16'h5000, 16'h7000, 16'h9000};
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(16'(rand_x()), 16'(rand_x()), (i == 0), (i == 6));
        idle(1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #2;
        check("bp_s_ready", int'(s_ready), 0);
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join
    idle(4);

    // Randomized traffic with random back-pressure and gaps.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) inv_step = {$urandom, $urandom};
      send(16'(rand_x()), 16'(rand_x()), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    rdy_mode = 0;
    idle(4);

    // Reset mid-burst, then a fresh sof beat.
    inv_step = {4{16'h4000}};
    send(16'sd1024, 16'sd2048, 1'b1, 1'b0);
    send(16'sd3072, 16'sd4096, 1'b0, 1'b0);
    send(16'sd5120, 16'sd6144, 1'b0, 1'b0);
    rst     = 1'b1;
    s_valid = 1'b0;
    #1;
    check("midrst_valid", int'(m_valid), 0);
    check("midrst_data", int'(m_data), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    inv_step = {4{16'h2000}};
    send(-16'sd8192, 16'sd8192, 1'b1, 1'b0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_valid", int'(m_valid), 1);
    check("post_rst_q_high", $signed(m_data[31:16]), -2);
    check("post_rst_q_low", $signed(m_data[15:0]), 2);
    idle(2);

    guard = 0;
    while (expq.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("drain_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
